// File: rtl/scheduler_spawnout_reader.sv
// scheduler_spawnout_reader: polls the spawn-out queue header at rIdx, streams each valid
// entry word-by-word on AXI4-Stream, then clears the header's valid byte to free the slots.
module scheduler_spawnout_reader #(
    parameter int QUEUE_LEN = 1024,
    parameter int QUEUE_BITS = $clog2(QUEUE_LEN),
    parameter int ENTRY_VALID_OFFSET = 63,
    parameter int ENTRY_VALID_BYTE_OFFSET = 56,
    parameter int NUM_ARGS_OFFSET = 32,
    parameter int NUM_DEPS_OFFSET = 40,
    parameter int NUM_COPS_OFFSET = 48
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [31:0]           spawnout_queue_addr,
    output logic                  spawnout_queue_en,
    output logic [7:0]            spawnout_queue_we,
    output logic [63:0]           spawnout_queue_din,
    input  logic [63:0]           spawnout_queue_dout,
    output logic [63:0]           outStream_TDATA,
    output logic                  outStream_TVALID,
    input  logic                  outStream_TREADY,
    output logic                  outStream_TLAST,
    output logic [QUEUE_BITS-1:0] rIdx_o
);
    typedef enum logic [2:0] {IDLE, HEADER, SEND, READ, CAPTURE, CLEAR} state_t;

    state_t state, state_nxt;
    logic [QUEUE_BITS-1:0] ridx, cur;
    logic [6:0] remaining, hdr_len, len;
    logic [63:0] data_buf;
    logic hdr_valid;

    assign hdr_valid = spawnout_queue_dout[ENTRY_VALID_OFFSET];
    assign len = 7'd4 + 7'(spawnout_queue_dout[NUM_DEPS_OFFSET +: 4])
               + 7'(spawnout_queue_dout[NUM_ARGS_OFFSET +: 4])
               + 7'd3 * 7'(spawnout_queue_dout[NUM_COPS_OFFSET +: 4]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = HEADER;
            HEADER:  state_nxt = hdr_valid ? SEND : IDLE;
            SEND:    if (outStream_TREADY) state_nxt = (remaining == 7'd0) ? CLEAR : READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ridx      <= '0;
            cur       <= '0;
            remaining <= '0;
            hdr_len   <= '0;
            data_buf  <= '0;
        end else begin
            state <= state_nxt;
            if (state == HEADER && hdr_valid) begin
                data_buf  <= spawnout_queue_dout;
                remaining <= len - 7'd1;
                cur       <= ridx;
                hdr_len   <= len;
            end
            if (state == SEND && outStream_TREADY && remaining != 7'd0) begin
                cur       <= cur + QUEUE_BITS'(1);
                remaining <= remaining - 7'd1;
            end
            if (state == CAPTURE) data_buf <= spawnout_queue_dout;
            // Index arithmetic wraps naturally at QUEUE_BITS
            if (state == CLEAR) ridx <= ridx + QUEUE_BITS'(hdr_len);
        end
    end

    // en/we are gated by rstn so nothing reaches the BRAM while reset is held
    assign spawnout_queue_en   = rstn && (state == IDLE || state == READ || state == CLEAR);
    assign spawnout_queue_we   = (rstn && state == CLEAR) ? 8'(8'h01 << (ENTRY_VALID_BYTE_OFFSET / 8)) : 8'h00;
    assign spawnout_queue_addr = 32'(state == READ ? cur : ridx) << 3;
    assign spawnout_queue_din  = '0;
    assign outStream_TVALID    = state == SEND;
    assign outStream_TLAST     = state == SEND && remaining == 7'd0;
    assign outStream_TDATA     = data_buf;
    assign rIdx_o              = ridx;
endmodule

// File: tb/tb_scheduler_spawnout_reader.sv
// tb_scheduler_spawnout_reader: random entries through a BRAM model, checked against
// a per-entry reference built from the header counts and the written words.
module tb_scheduler_spawnout_reader;
    localparam int QL = 1024;
    localparam int QB = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [31:0] addr;
    logic en;
    logic [7:0] we;
    logic [63:0] din, dout, tdata;
    logic tvalid, tlast;
    logic tready = 1'b0;
    logic [QB-1:0] ridx;

    scheduler_spawnout_reader #(.QUEUE_LEN(QL)) dut (
        .clk(clk), .rstn(rstn),
        .spawnout_queue_addr(addr), .spawnout_queue_en(en), .spawnout_queue_we(we),
        .spawnout_queue_din(din), .spawnout_queue_dout(dout),
        .outStream_TDATA(tdata), .outStream_TVALID(tvalid), .outStream_TREADY(tready),
        .outStream_TLAST(tlast), .rIdx_o(ridx)
    );

    always #5 clk = ~clk;

    bit [63:0] mem [QL];
    logic host_we = 1'b0;
    logic [QB-1:0] host_addr = '0;
    logic [63:0] host_data = '0;
    int wr_count = 0;

    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_data;
        if (en) begin
            for (int b = 0; b < 8; b++) if (we[b]) mem[addr[12:3]][8*b +: 8] <= din[8*b +: 8];
            if (we != 8'h00) wr_count <= wr_count + 1;
            dout <= mem[addr[12:3]];
        end
    end

    int n_assert = 0, n_fail = 0, ncyc = 0, mode = 0, model_ridx = 0;
    logic [63:0] got_d[$];
    logic got_l[$];
    int rd_q[$];
    bit active, cleared, prev_stall;
    int first_cyc, clear_cyc;
    logic [31:0] clear_addr;
    logic [7:0] clear_we;
    logic [63:0] clear_din, prev_d;
    logic prev_l;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        ncyc++;
        tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~tready : 1'($urandom_range(1));
        if (tvalid && prev_stall) begin
            chk("stall_tdata", tdata, prev_d);
            chk("stall_tlast", tlast, prev_l);
        end
        if (en && we != 8'h00) begin
            cleared = 1; clear_cyc = ncyc; clear_addr = addr; clear_we = we; clear_din = din;
        end else if (en && active && !cleared) rd_q.push_back(int'(addr >> 3));
        if (tvalid && !active) begin active = 1; first_cyc = ncyc; end
        if (tvalid && tready) begin got_d.push_back(tdata); got_l.push_back(tlast); end
        prev_stall = tvalid && !tready; prev_d = tdata; prev_l = tlast;
    endtask

    task automatic hwrite(input int idx, input logic [63:0] d);
        host_we = 1'b1; host_addr = QB'(idx); host_data = d;
        cyc();
        host_we = 1'b0;
    endtask

    task automatic reset_mon();
        got_d.delete(); got_l.delete(); rd_q.delete();
        active = 0; cleared = 0; prev_stall = 0;
    endtask

    task automatic build(input int a, input int d, input int c, output logic [63:0] w[$]);
        logic [63:0] hdr, wd;
        hdr = {$urandom, $urandom};
        hdr[63] = 1'b1; hdr[35:32] = 4'(a); hdr[43:40] = 4'(d); hdr[51:48] = 4'(c);
        w.delete();
        w.push_back(hdr);
        for (int i = 1; i < 4 + a + d + 3 * c; i++) begin
            wd = {$urandom, $urandom}; wd[63] = 1'b0;
            w.push_back(wd);
        end
    endtask

    task automatic send_entry(input int a, input int d, input int c, input int m);
        int l, start, k;
        logic [63:0] w[$];
        bit ok;
        l = 4 + a + d + 3 * c;
        start = model_ridx;
        build(a, d, c, w);
        mode = m;
        reset_mon();
        for (int i = 1; i < l; i++) hwrite((start + i) % QL, w[i]);
        hwrite(start, w[0]);
        k = 0;
        while (!cleared && k < 2000) begin cyc(); k++; end
        chk("entry_done", 64'(cleared), 64'd1);
        cyc();
        chk("next_poll_en", en, 1);
        chk("next_poll_we", we, 0);
        chk("next_poll_addr", addr, 64'(((start + l) % QL) * 8));
        chk("nwords", got_d.size(), l);
        ok = 1;
        for (int i = 0; i < l; i++)
            if (i >= got_d.size() || got_d[i] !== w[i] || got_l[i] !== (i == l - 1)) ok = 0;
        chk("words_tlast", 64'(ok), 64'd1);
        ok = (rd_q.size() == l - 1);
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != (start + i + 1) % QL) ok = 0;
        chk("read_addrs", 64'(ok), 64'd1);
        chk("clear_addr", clear_addr, 64'(start * 8));
        chk("clear_we", clear_we, 8'h80);
        chk("clear_din_vbyte", clear_din[63:56], 0);
        chk("hdr_after_clear", mem[start], w[0] & ~(64'hFF << 56));
        model_ridx = (start + l) % QL;
        chk("ridx", ridx, 64'(model_ridx));
        if (m == 0) chk("latency", clear_cyc - first_cyc, 3 * l - 2);
    endtask

    task automatic advance_to(input int target);
        int n, l, r, a, d, c;
        while (model_ridx != target) begin
            n = (target - model_ridx + QL) % QL;
            if (n < 4) n += QL;
            l = (n > 79) ? ((n - 79 >= 4) ? 79 : 70) : n;
            r = l - 4;
            c = (r > 30) ? (r - 30 + 2) / 3 : 0;
            a = (r - 3 * c > 15) ? 15 : r - 3 * c;
            d = r - 3 * c - a;
            send_entry(a, d, c, 2);
        end
    endtask

    initial begin
        int cnt, k, wc;
        bit bad_v, bad_a, bad_alt, prev_en;
        logic [63:0] w[$];
        repeat (3) cyc();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_en", en, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_ridx", ridx, 0);
        rstn = 1'b1;
        // empty queue: poll every 2 cycles at addr 0, never valid
        cnt = 0; bad_v = 0; bad_a = 0; bad_alt = 0; prev_en = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (tvalid) bad_v = 1;
            if (addr != 0) bad_a = 1;
            if (en) cnt++;
            if (i > 0 && en == prev_en) bad_alt = 1;
            prev_en = en;
        end
        chk("empty_tvalid", 64'(bad_v), 0);
        chk("empty_addr", 64'(bad_a), 0);
        chk("empty_en_alt", 64'(bad_alt), 0);
        chk("empty_en_count", cnt, 50);
        send_entry(1, 0, 0, 0);
        chk("min_ridx", ridx, 5);
        send_entry(3, 0, 0, 1);
        repeat (4) send_entry($urandom_range(15), $urandom_range(15), $urandom_range(5), 2);
        send_entry(15, 15, 15, 0);
        advance_to(QL - 2);
        send_entry(0, 2, 0, 0);
        chk("wrap_ridx", ridx, 4);
        // reset on the third word: abort with no clear write
        build(3, 0, 0, w);
        mode = 0;
        reset_mon();
        for (int i = 1; i < 7; i++) hwrite((model_ridx + i) % QL, w[i]);
        hwrite(model_ridx, w[0]);
        k = 0;
        while (!(got_d.size() == 2 && tvalid) && k < 500) begin cyc(); k++; end
        chk("third_word_reached", 64'(got_d.size() == 2 && tvalid), 1);
        #2 rstn = 1'b0;
        wc = wr_count;
        #1;
        chk("abort_tvalid", tvalid, 0);
        chk("abort_en", en, 0);
        chk("abort_ridx", ridx, 0);
        repeat (2) cyc();
        rstn = 1'b1;
        model_ridx = 0;
        bad_v = 0;
        for (int i = 0; i < 30; i++) begin cyc(); if (tvalid) bad_v = 1; end
        chk("abort_no_write", wr_count, wc);
        chk("abort_quiet", 64'(bad_v), 0);
        chk("abort_ridx_after", ridx, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
